pc_sequencer: RTL and testbench

//  Next-PC controller for the RV32I fetch stage. Owns the PC register and chooses each cycle between

---
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the RV32I fetch stage.
// Owns the PC, drives the instruction-memory request handshake, and
// discards a fetch that a redirect has made stale.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        trap,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        kill;

    logic        redir;
    logic [31:0] sel_target;
    logic [31:0] target;
    logic        target_misaligned;

    // Pick the redirect target (trap > jump > branch) and word-align it
    always_comb begin
        redir      = trap | jump | branch_taken;
        sel_target = branch_target;
        if (jump) begin
            sel_target = jump_target;
        end
        if (trap) begin
            sel_target = TRAP_VECTOR;
        end
        target            = {sel_target[31:2], 2'b00};
        target_misaligned = redir & ~trap & (sel_target[1:0] != 2'b00);
    end

    assign imem_req  = (state == ST_WAIT);
    assign imem_addr = pc;

    // Fetch FSM: PC update, stale-fetch cancellation and instruction delivery
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_VECTOR;
            pend_pc     <= RESET_VECTOR;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
            misalign    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            misalign    <= target_misaligned;
            case (state)
                ST_IDLE: begin
                    if (redir) begin
                        pc <= target;
                    end else if (!stall) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!imem_ready) begin
                        if (redir) begin
                            pend_pc <= target;
                            kill    <= 1'b1;
                        end
                    end else begin
                        if (!kill && !redir) begin
                            instr_valid <= 1'b1;
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                        end
                        if (redir) begin
                            pc <= target;
                        end else if (kill) begin
                            pc <= pend_pc;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                        kill  <= 1'b0;
                        state <= stall ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario-driven bench for pc_sequencer with a delivery scoreboard.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;

    int compared;
    int mismatched;
    int unsigned cyc;

    typedef struct {
        int unsigned due;
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_exp_v;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .misalign      (misalign)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so scoreboard entries know which cycle they are due in
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Delivery monitor: instr_valid must match the scoreboard every cycle
    always @(negedge clk) begin
        mon_exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        compared++;
        if (instr_valid !== mon_exp_v) begin
            mismatched++;
            $display("[TB] FAIL instr_valid cyc=%0d: got %b expected %b", cyc, instr_valid, mon_exp_v);
        end
        if (mon_exp_v) begin
            mon_e = sb.pop_front();
            compared++;
            if (instr !== mon_e.data) begin
                mismatched++;
                $display("[TB] FAIL instr cyc=%0d: got %h expected %h", cyc, instr, mon_e.data);
            end
            compared++;
            if (instr_pc !== mon_e.pc) begin
                mismatched++;
                $display("[TB] FAIL instr_pc cyc=%0d: got %h expected %h", cyc, instr_pc, mon_e.pc);
            end
        end
    end

    task automatic expect_delivery(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.due  = cyc + 1;
        e.pc   = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        trap          = 1'b0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
    endtask

    // Returns at a falling edge with reset just released; DUT is IDLE at pc=0
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        compared++;
        if (imem_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_req: got %b expected 0", imem_req);
        end
        compared++;
        if (imem_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr);
        end
        compared++;
        if ({instr_valid, misalign, instr, instr_pc} !== 66'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got v=%b m=%b i=%h p=%h expected all 0",
                     instr_valid, misalign, instr, instr_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        do_reset();
        imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = 32'(k * 4);
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                mismatched++;
                $display("[TB] FAIL seq_addr k=%0d: got req=%b addr=%h expected req=1 addr=%h",
                         k, imem_req, imem_addr, a);
            end
            imem_rdata = 32'h1000_0000 + 32'(k);
            expect_delivery(a, imem_rdata);
        end
    endtask

    task automatic test_ready_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL wait_hold i=%0d: got req=%b addr=%h expected req=1 addr=00000000",
                         i, imem_req, imem_addr);
            end
            if (i == 3) begin
                imem_ready = 1'b1;
                imem_rdata = 32'h2222_AAAA;
                expect_delivery(32'h0, imem_rdata);
            end
        end
        @(negedge clk);
        imem_ready = 1'b0;
        compared++;
        if (imem_addr !== 32'h4) begin
            mismatched++;
            $display("[TB] FAIL wait_next: got %h expected 00000004", imem_addr);
        end
    endtask

    task automatic test_branch_kill();
        do_reset();
        imem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            imem_rdata = 32'h3000_0000 + 32'(k);
            expect_delivery(32'(k * 4), imem_rdata);
        end
        @(negedge clk);
        compared++;
        if (imem_addr !== 32'h8) begin
            mismatched++;
            $display("[TB] FAIL kill_pre: got %h expected 00000008", imem_addr);
        end
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            mismatched++;
            $display("[TB] FAIL kill_hold: got req=%b addr=%h expected req=1 addr=00000008",
                     imem_req, imem_addr);
        end
        compared++;
        if (misalign !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL kill_misalign: got %b expected 0", misalign);
        end
        branch_taken = 1'b0;
        @(negedge clk);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ready = 1'b0;
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            mismatched++;
            $display("[TB] FAIL kill_redirect: got req=%b addr=%h expected req=1 addr=00000040",
                     imem_req, imem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge clk);
        trap          = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h82;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        imem_ready    = 1'b1;
        imem_rdata    = 32'h4444_4444;
        @(negedge clk);
        clear_inputs();
        compared++;
        if (imem_addr !== 32'h100) begin
            mismatched++;
            $display("[TB] FAIL prio_addr: got %h expected 00000100", imem_addr);
        end
        compared++;
        if (misalign !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL prio_misalign: got %b expected 0", misalign);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign_wrap();
        do_reset();
        jump        = 1'b1;
        jump_target = 32'h42;
        @(negedge clk);
        jump = 1'b0;
        compared++;
        if (misalign !== 1'b1 || imem_addr !== 32'h40 || imem_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mis_pulse: got m=%b addr=%h req=%b expected m=1 addr=00000040 req=0",
                     misalign, imem_addr, imem_req);
        end
        @(negedge clk);
        compared++;
        if (misalign !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mis_clear: got m=%b addr=%h req=%b expected m=0 addr=00000040 req=1",
                     misalign, imem_addr, imem_req);
        end
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        imem_ready  = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        compared++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            mismatched++;
            $display("[TB] FAIL wrap_top: got %h expected fffffffc", imem_addr);
        end
        imem_rdata = 32'h5555_0001;
        expect_delivery(32'hFFFF_FFFC, imem_rdata);
        @(negedge clk);
        imem_ready = 1'b0;
        compared++;
        if (imem_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL wrap_zero: got %h expected 00000000", imem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_reset();
        do_reset();
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL stall_hold: got req=%b addr=%h expected req=1 addr=00000000",
                     imem_req, imem_addr);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h6666_0000;
        expect_delivery(32'h0, imem_rdata);
        @(negedge clk);
        imem_ready = 1'b0;
        compared++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin
            mismatched++;
            $display("[TB] FAIL stall_idle: got req=%b addr=%h expected req=0 addr=00000004",
                     imem_req, imem_addr);
        end
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_stay: got req=%b expected 0", imem_req);
        end
        stall = 1'b0;
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            mismatched++;
            $display("[TB] FAIL stall_resume: got req=%b addr=%h expected req=1 addr=00000004",
                     imem_req, imem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset: got req=%b addr=%h expected req=0 addr=00000000",
                     imem_req, imem_addr);
        end
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midreset_restart: got req=%b addr=%h expected req=1 addr=00000000",
                     imem_req, imem_addr);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        $display("[TB] starting pc_sequencer scenarios");
        test_reset();
        test_sequential();
        test_ready_wait();
        test_branch_kill();
        test_priority();
        test_misalign_wrap();
        test_stall_reset();
        repeat (2) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
